// File: rtl/wb_sequencer_pkg.sv
// wb_sequencer_pkg: widths, opcodes, FSM states and accept-time dispatch for the write-back sequencer
package wb_sequencer_pkg;
  localparam int DATA_W = 8;
  localparam int REG_AW = 3;
  localparam int MEM_AW = 4;
  localparam int PC_W = 6;
  localparam logic [4:0] OP_MOVE = 5'd0, OP_ADD = 5'd1, OP_SUB = 5'd2, OP_AND = 5'd3,
                         OP_OR = 5'd4, OP_XOR = 5'd5, OP_COMPARE = 5'd6, OP_LOAD = 5'd7,
                         OP_STORE = 5'd8, OP_MUL = 5'd9, OP_DIV = 5'd10, OP_INC = 5'd11,
                         OP_DEC = 5'd12, OP_NOT = 5'd13, OP_ASHL = 5'd14, OP_ASHR = 5'd15,
                         OP_LSHL = 5'd16, OP_LSHR = 5'd17, OP_ROTL = 5'd18, OP_ROTR = 5'd19,
                         OP_JUMP = 5'd20, OP_BEQZ = 5'd21, OP_BC = 5'd22, OP_BAUX = 5'd23,
                         OP_BPAR = 5'd24, OP_HALT = 5'b11111;
  typedef enum logic [2:0] {S_IDLE, S_REG_LO, S_REG_HI, S_MEM_WR, S_BRANCH, S_HALT, S_NOP} state_e;
  typedef struct packed {
    logic [4:0]          op;
    logic [REG_AW-1:0]   rd;
    logic [MEM_AW-1:0]   mem_addr;
    logic [PC_W-1:0]     target;
    logic [2*DATA_W-1:0] alu;
    logic                z;
    logic                c;
    logic                a;
    logic                p;
  } cap_t;
  function automatic state_e dispatch(input logic [4:0] op, input logic am);
    case (op) inside
      [OP_MOVE:OP_LOAD], OP_MUL, OP_DIV: dispatch = S_REG_LO;
      OP_STORE:                          dispatch = S_MEM_WR;
      [OP_INC:OP_ROTR]:                  dispatch = am ? S_MEM_WR : S_REG_LO;
      [OP_JUMP:OP_BPAR]:                 dispatch = S_BRANCH;
      OP_HALT:                           dispatch = S_HALT;
      default:                           dispatch = S_NOP;
    endcase
  endfunction
endpackage

// File: rtl/wb_sequencer_if.sv
// wb_sequencer_if: execute-stage handshake plus register-file, memory and PC write ports
interface wb_sequencer_if;
  import wb_sequencer_pkg::*;
  logic                wb_valid, wb_ready;
  logic [4:0]          opcode;
  logic                am;
  logic [REG_AW-1:0]   rd;
  logic [MEM_AW-1:0]   mem_addr;
  logic [PC_W-1:0]     instr_mem_addr;
  logic [2*DATA_W-1:0] alu_out;
  logic                zero_flag, carry_flag, auxiliary_flag, parity_flag;
  logic                reg_we;
  logic [REG_AW-1:0]   reg_waddr;
  logic [DATA_W-1:0]   reg_wdata;
  logic                mem_we;
  logic [MEM_AW-1:0]   mem_waddr;
  logic [DATA_W-1:0]   mem_wdata;
  logic                loadPC;
  logic [PC_W-1:0]     pc_target;
  logic                HALTED;
  modport master (
    output wb_valid, opcode, am, rd, mem_addr, instr_mem_addr, alu_out,
           zero_flag, carry_flag, auxiliary_flag, parity_flag,
    input  wb_ready, reg_we, reg_waddr, reg_wdata, mem_we, mem_waddr, mem_wdata,
           loadPC, pc_target, HALTED
  );
  modport slave (
    input  wb_valid, opcode, am, rd, mem_addr, instr_mem_addr, alu_out,
           zero_flag, carry_flag, auxiliary_flag, parity_flag,
    output wb_ready, reg_we, reg_waddr, reg_wdata, mem_we, mem_waddr, mem_wdata,
           loadPC, pc_target, HALTED
  );
endinterface

// File: rtl/wb_branch_cond.sv
// wb_branch_cond: decides whether a branch opcode is taken from its latched flags
module wb_branch_cond
  import wb_sequencer_pkg::*;
(
  input  logic [4:0] opcode_i,
  input  logic       zero_i,
  input  logic       carry_i,
  input  logic       aux_i,
  input  logic       parity_i,
  output logic       taken_o
);
  assign taken_o = (opcode_i == OP_JUMP) || (opcode_i == OP_BEQZ && zero_i) ||
                   (opcode_i == OP_BC && carry_i) || (opcode_i == OP_BAUX && aux_i) ||
                   (opcode_i == OP_BPAR && parity_i);
endmodule

// File: rtl/wb_sequencer.sv
// wb_sequencer: turns each accepted retired instruction into one-cycle reg/mem/PC write strobes or a sticky halt
module wb_sequencer
  import wb_sequencer_pkg::*;
(
  input logic          clk,
  input logic          reset,
  wb_sequencer_if.slave bus
);
  state_e state_q, state_d;
  cap_t   cap_q, cap_d;
  logic   accept, taken, wide, lo, hi;
  assign accept = bus.wb_valid && bus.wb_ready;
  assign wide = (cap_q.op == OP_MUL) || (cap_q.op == OP_DIV);
  wb_branch_cond u_cond (
    .opcode_i (cap_q.op),
    .zero_i   (cap_q.z),
    .carry_i  (cap_q.c),
    .aux_i    (cap_q.a),
    .parity_i (cap_q.p),
    .taken_o  (taken)
  );
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      cap_q   <= '0;
    end else begin
      state_q <= state_d;
      cap_q   <= cap_d;
    end
  end
  always_comb begin
    cap_d = accept ? cap_t'{op: bus.opcode, rd: bus.rd, mem_addr: bus.mem_addr,
                            target: bus.instr_mem_addr, alu: bus.alu_out, z: bus.zero_flag,
                            c: bus.carry_flag, a: bus.auxiliary_flag, p: bus.parity_flag} : cap_q;
    state_d = state_q == S_IDLE ? (accept ? dispatch(bus.opcode, bus.am) : S_IDLE) :
              state_q == S_HALT ? S_HALT :
              (state_q == S_REG_LO && wide) ? S_REG_HI : S_IDLE;
  end
  // Strobes are masked while reset is high so an interrupted sequence never completes its write
  assign lo = state_q == S_REG_LO && !reset;
  assign hi = state_q == S_REG_HI && !reset;
  assign bus.wb_ready  = state_q == S_IDLE;
  assign bus.HALTED    = state_q == S_HALT;
  assign bus.reg_we    = lo || hi;
  assign bus.reg_waddr = lo ? cap_q.rd : hi ? cap_q.rd + REG_AW'(1) : '0;
  assign bus.reg_wdata = lo ? cap_q.alu[DATA_W-1:0] : hi ? cap_q.alu[2*DATA_W-1:DATA_W] : '0;
  assign bus.mem_we    = state_q == S_MEM_WR && !reset;
  assign bus.mem_waddr = bus.mem_we ? cap_q.mem_addr : '0;
  assign bus.mem_wdata = bus.mem_we ? cap_q.alu[DATA_W-1:0] : '0;
  assign bus.loadPC    = state_q == S_BRANCH && taken && !reset;
  assign bus.pc_target = bus.loadPC ? cap_q.target : '0;
endmodule
